// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sharing one I2C master among N_REQ requesters.
// Ports: clk/rst (sync, active-high); req/req_addr/req_op/req_din requester payloads;
// gnt/rsp_valid/rsp_data/rsp_err/rsp_timeout per-requester handshake; m_* master request/status;
// err_count saturating NACK+timeout counter.
module i2c_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [8*N_REQ-1:0] req_din,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               m_newd,
  output logic               m_op,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_din,
  input  logic               m_busy,
  input  logic               m_done,
  input  logic               m_ack_err,
  input  logic [7:0]         m_dout,
  output logic [15:0]        err_count
);
  localparam int WW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, DRAIN} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] w_q, w_d, last_w_q, last_w_d, win, j;
  logic [6:0] addr_q, addr_d;
  logic op_q, op_d, err_q, err_d, to_q, to_d;
  logic [7:0] din_q, din_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] ecnt_q, ecnt_d;
  // Descending scan so the requester closest after last_w is the final assignment.
  always_comb begin
    win = last_w_q;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = WW'((int'(last_w_q) + 1 + k) % N_REQ);
      if (req[j]) win = j;
    end
  end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    last_w_d = last_w_q;
    addr_d = addr_q;
    op_d = op_q;
    din_d = din_q;
    cnt_d = cnt_q;
    data_d = data_q;
    err_d = err_q;
    to_d = to_q;
    ecnt_d = ecnt_q;
    case (state_q)
      IDLE: if (|req && !m_busy) begin
        state_d = ISSUE;
        w_d = win;
        addr_d = req_addr[7*win +: 7];
        op_d = req_op[win];
        din_d = req_din[8*win +: 8];
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        cnt_d = '0;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (m_done) begin
          state_d = RESP;
          err_d = m_ack_err;
          to_d = 1'b0;
          data_d = op_q ? m_dout : 8'h00;
        end else if (cnt_d == CW'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          err_d = 1'b0;
          to_d = 1'b1;
          data_d = 8'h00;
        end
      end
      RESP: begin
        last_w_d = w_q;
        ecnt_d = ((err_q || to_q) && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;
        state_d = m_busy ? DRAIN : IDLE;
      end
      DRAIN: state_d = m_busy ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q <= '0;
      last_w_q <= WW'(N_REQ - 1);
      addr_q <= '0;
      op_q <= 1'b0;
      din_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      last_w_q <= last_w_d;
      addr_q <= addr_d;
      op_q <= op_d;
      din_q <= din_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      err_q <= err_d;
      to_q <= to_d;
      ecnt_q <= ecnt_d;
    end
  end
  assign m_newd = state_q == ISSUE;
  assign gnt = m_newd ? N_REQ'(1) << w_q : '0;
  assign rsp_valid = (state_q == RESP) ? N_REQ'(1) << w_q : '0;
  assign m_addr = addr_q;
  assign m_op = op_q;
  assign m_din = din_q;
  assign rsp_data = data_q;
  assign rsp_err = err_q;
  assign rsp_timeout = to_q;
  assign err_count = ecnt_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed self-checking bench for i2c_req_arbiter.
module tb_i2c_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, req_op = '0, gnt, rsp_valid;
  logic [27:0] req_addr = '0;
  logic [31:0] req_din = '0;
  logic [7:0] rsp_data, m_din, m_dout = '0;
  logic rsp_err, rsp_timeout, m_newd, m_op;
  logic [6:0] m_addr;
  logic m_busy = 1'b0, m_done = 1'b0, m_ack_err = 1'b0;
  logic [15:0] err_count;
  int checks = 0, passes = 0;
  logic [3:0] g;
  int n;

  i2c_req_arbiter #(.N_REQ(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_op(req_op), .req_din(req_din),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .m_newd(m_newd), .m_op(m_op), .m_addr(m_addr), .m_din(m_din),
    .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_dout(m_dout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_gnt(output logic [3:0] gg);
    gg = '0;
    for (int i = 0; i < 20 && gg == 0; i++) begin
      tick();
      gg = gnt;
    end
    chk("gnt_seen", {31'd0, gg != 0}, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_newd", m_newd, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    // single write from requester 2
    req = 4'b0100;
    req_addr[14 +: 7] = 7'h50;
    req_din[16 +: 8] = 8'hA5;
    tick();
    chk("wr_newd", m_newd, 1);
    chk("wr_gnt", gnt, 4'b0100);
    chk("wr_addr", m_addr, 7'h50);
    chk("wr_din", m_din, 8'hA5);
    chk("wr_op", m_op, 0);
    req = '0;
    m_busy = 1'b1;
    tick();
    chk("wr_newd_low", m_newd, 0);
    chk("wr_gnt_low", gnt, 0);
    chk("wr_addr_hold", m_addr, 7'h50);
    tick();
    m_done = 1'b1;
    m_dout = 8'hFF;
    tick();
    chk("wr_rsp_valid", rsp_valid, 4'b0100);
    chk("wr_rsp_data", rsp_data, 8'h00);
    chk("wr_rsp_err", rsp_err, 0);
    m_done = 1'b0;
    m_busy = 1'b0;
    tick();
    chk("wr_rsp_low", rsp_valid, 0);
    chk("wr_err_count", err_count, 0);
    // read from requester 0
    req = 4'b0001;
    req_op = 4'b0001;
    req_addr[0 +: 7] = 7'h21;
    wait_gnt(g);
    chk("rd_gnt", g, 4'b0001);
    chk("rd_op", m_op, 1);
    chk("rd_addr", m_addr, 7'h21);
    req = '0;
    m_busy = 1'b1;
    tick();
    m_done = 1'b1;
    m_dout = 8'h3C;
    tick();
    chk("rd_rsp_valid", rsp_valid, 4'b0001);
    chk("rd_rsp_data", rsp_data, 8'h3C);
    chk("rd_rsp_err", rsp_err, 0);
    m_done = 1'b0;
    m_busy = 1'b0;
    tick();
    chk("rd_data_hold", rsp_data, 8'h3C);
    // NACK from requester 1
    req = 4'b0010;
    req_op = '0;
    wait_gnt(g);
    chk("nack_gnt", g, 4'b0010);
    req = '0;
    m_busy = 1'b1;
    tick();
    m_done = 1'b1;
    m_ack_err = 1'b1;
    tick();
    chk("nack_rsp_valid", rsp_valid, 4'b0010);
    chk("nack_rsp_err", rsp_err, 1);
    chk("nack_rsp_timeout", rsp_timeout, 0);
    m_done = 1'b0;
    m_ack_err = 1'b0;
    m_busy = 1'b0;
    tick();
    chk("nack_err_count", err_count, 1);
    // fairness after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err_count", err_count, 0);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_gnt(g);
      chk($sformatf("rr_gnt%0d", i), g, 4'b0001 << (i % 4));
      m_busy = 1'b1;
      tick();
      m_done = 1'b1;
      tick();
      chk($sformatf("rr_rsp%0d", i), rsp_valid, g);
      m_done = 1'b0;
      m_busy = 1'b0;
    end
    // timeout on requester 0
    req = 4'b0001;
    wait_gnt(g);
    chk("to_gnt", g, 4'b0001);
    m_busy = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (rsp_valid == 0 && n < 100);
    chk("to_cycles", n, 64);
    chk("to_rsp_valid", rsp_valid, 4'b0001);
    chk("to_flag", rsp_timeout, 1);
    chk("to_err", rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drain_no_gnt%0d", i), gnt, 0);
    end
    chk("to_err_count", err_count, 1);
    m_busy = 1'b0;
    // reset during WAIT_DONE
    req = 4'b0110;
    wait_gnt(g);
    chk("mr_gnt", g, 4'b0010);
    m_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = 1'b0;
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_addr", m_addr, 0);
    chk("mr_din", m_din, 0);
    chk("mr_timeout", rsp_timeout, 0);
    chk("mr_err_count", err_count, 0);
    wait_gnt(g);
    chk("mr_next_gnt", g, 4'b0010);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 The block SHALL declare parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL declare parameter TIMEOUT_CYC, default 16384, max clk cycles from m_newd to m_done.
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  N_REQ  per-requester level request; payload stable while high.
REQ-006 req_addr  in  7*N_REQ  7-bit slave address per requester (slice i = bits 7i+6:7i).
REQ-007 req_op  in  N_REQ  per-requester op, 0 = write, 1 = read.
REQ-008 req_din  in  8*N_REQ  write byte per requester.
REQ-009 gnt  out  N_REQ  one-cycle pulse: payload of requester i captured.
REQ-010 rsp_valid  out  N_REQ  one-cycle pulse: response for requester i.
REQ-011 rsp_data  out  8  read byte, valid with rsp_valid.
REQ-012 rsp_err  out  1  slave NACK, valid with rsp_valid.
REQ-013 rsp_timeout  out  1  transaction timed out, valid with rsp_valid.
REQ-014 m_newd, m_op  out  1 each; m_addr  out  7; m_din  out  8  drive the I2C master request port.
REQ-015 m_busy, m_done, m_ack_err  in  1 each; m_dout  in  8  I2C master status and read data.
REQ-016 err_count  out  16  saturating count of NACK plus timeout responses.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE, RESP and DRAIN.
REQ-018 IDLE: when req != 0 and m_busy == 0, the FSM SHALL pick winner w by round-robin, capture w's addr/op/din into registers, and go to ISSUE.
REQ-019 Round-robin: the search SHALL start at index (last_w+1) mod N_REQ and pick the lowest index at or after it (with wrap); last_w resets to N_REQ-1, so requester 0 wins first.
REQ-020 ISSUE lasts exactly 1 cycle: m_newd = 1, gnt[w] = 1, m_addr/m_op/m_din = captured values; the FSM SHALL then go to WAIT_DONE and load the timeout counter to 0.
REQ-021 m_addr/m_op/m_din SHALL hold the captured values from ISSUE through RESP; m_newd SHALL be 0 outside ISSUE.
REQ-022 WAIT_DONE: the counter SHALL increment each cycle.
REQ-023 On m_done == 1 in WAIT_DONE, the FSM SHALL sample m_ack_err, and m_dout if op = 1 (else 8'h00), then go to RESP.
REQ-024 If the counter reaches TIMEOUT_CYC-1 without m_done, the FSM SHALL set a timeout flag and go to RESP; m_done in the same cycle takes precedence (no timeout).
REQ-025 RESP lasts exactly 1 cycle: rsp_valid[w] = 1, rsp_data, rsp_err, rsp_timeout = sampled values; last_w <= w.
REQ-026 After RESP the FSM SHALL go to DRAIN if m_busy == 1, else to IDLE.
REQ-027 DRAIN SHALL wait for m_busy == 0, then go to IDLE; no new grant is issued while m_busy == 1.
REQ-028 rsp_data/rsp_err/rsp_timeout SHALL hold their last values between pulses.
REQ-029 err_count SHALL increment in RESP when rsp_err or rsp_timeout is 1, and saturate at 16'hFFFF.
REQ-030 Requests deasserting before arbitration SHALL be ignored; req[w] dropping after gnt SHALL NOT abort the transaction.
REQ-031 At most one gnt bit and one rsp_valid bit SHALL be high in any cycle; minimum spacing between consecutive grants is 4 cycles.

Reset
REQ-032 rst SHALL force, on the next edge, from any state: state IDLE, gnt/rsp_valid/m_newd = 0, captured m_addr/m_op/m_din = 0, rsp_data = 0, rsp_err = 0, rsp_timeout = 0, err_count = 0, last_w = N_REQ-1, counter 0.
REQ-033 An in-flight transaction SHALL be abandoned on rst with no rsp_valid pulse.

Verification
REQ-034 Single write: req[2] = 1, addr = 7'h50, op = 0, din = 8'hA5, master ACKs -> gnt[2] once, m_newd one cycle with m_addr = 7'h50 and m_din = 8'hA5; rsp_valid[2] 1 cycle after m_done, rsp_err = 0, rsp_data = 8'h00.
REQ-035 Read: req[0] op = 1, slave returns 8'h3C -> rsp_valid[0] with rsp_data = 8'h3C, rsp_err = 0.
REQ-036 Fairness: all 4 req held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-037 NACK: slave absent -> rsp_err = 1, rsp_timeout = 0, err_count = 1.
REQ-038 Timeout: TIMEOUT_CYC = 64, m_done never asserted -> rsp_valid with rsp_timeout = 1 at cycle 64 after m_newd; no further grant while m_busy = 1.
REQ-039 Mid-transaction reset: rst pulsed in WAIT_DONE -> no rsp_valid; all outputs at reset values; the next grant goes to the lowest active req index.
